uc_multiciclo: RTL and testbench



---
 rtl/nrisc_pkg.sv | 52 +++++
 rtl/uc_multiciclo_if.sv | 44 ++++
 rtl/uc_multiciclo_ula_controle.sv | 33 +++
 rtl/uc_multiciclo.sv | 160 ++++++++++++++++
 tb/tb_uc_multiciclo.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/nrisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nrisc_pkg
// Description : Shared encodings for the 8-bit nRISC core: opcodes, ULAOp
//               codes, control-unit states and datapath select values.
// Revision    : 1.0 - initial release
// ============================================================================
package nrisc_pkg;

  // Opcodes carried in IR[7:5]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_J    = 3'b111;

  // ALU operation codes
  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_SLT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] FONTE_B_REG = 2'b00;
  localparam logic [1:0] FONTE_B_IMM = 2'b01;
  localparam logic [1:0] FONTE_B_UM  = 2'b10;

  // PC source select
  localparam logic [1:0] PC_ULA      = 2'b00;
  localparam logic [1:0] PC_ULASAIDA = 2'b01;
  localparam logic [1:0] PC_SALTO    = 2'b10;

  // Control-unit states (codes 12..15 are unreachable)
  typedef enum logic [3:0] {
    INICIO   = 4'd0,
    BUSCA    = 4'd1,
    DECOD    = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    ESCR_ULA = 4'd5,
    CALC_END = 4'd6,
    LE_MEM   = 4'd7,
    ESCR_MEM = 4'd8,
    ESC_MEM  = 4'd9,
    DESVIO   = 4'd10,
    SALTO    = 4'd11
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/uc_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module      : uc_multiciclo_if
// Description : Control bus between the multicycle control unit (master) and
//               the nRISC datapath/memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface uc_multiciclo_if #(
  parameter int CONT_LARGURA = 8
);
  // Status into the control unit
  logic [2:0]              opcode;
  logic                    zero;
  logic                    mem_pronta;
  // Control out of the control unit
  logic [1:0]              ula_op;
  logic                    ula_fonte_a;
  logic [1:0]              ula_fonte_b;
  logic [1:0]              pc_fonte;
  logic                    escreve_pc;
  logic                    escreve_ir;
  logic                    iord;
  logic                    le_mem;
  logic                    escreve_mem;
  logic                    mem_para_reg;
  logic                    escreve_reg;
  logic [3:0]              estado;
  logic [CONT_LARGURA-1:0] instr_concluidas;

  modport master (
    input  opcode, zero, mem_pronta,
    output ula_op, ula_fonte_a, ula_fonte_b, pc_fonte, escreve_pc, escreve_ir,
           iord, le_mem, escreve_mem, mem_para_reg, escreve_reg, estado,
           instr_concluidas
  );

  modport slave (
    output opcode, zero, mem_pronta,
    input  ula_op, ula_fonte_a, ula_fonte_b, pc_fonte, escreve_pc, escreve_ir,
           iord, le_mem, escreve_mem, mem_para_reg, escreve_reg, estado,
           instr_concluidas
  );
endinterface
`default_nettype wire

// File: rtl/uc_multiciclo_ula_controle.sv
`default_nettype none
// ============================================================================
// Module      : ula_controle
// Description : Maps control state and latched opcode to the 2-bit ULAOp.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_controle
  import nrisc_pkg::*;
(
  input  estado_t    i_estado,
  input  logic [2:0] i_opcode,
  output logic [1:0] o_ula_op
);

  // R-type picks its operation from the opcode, BEQ compares by subtraction,
  // every other state uses the adder (PC+1, branch target, address calc).
  always_comb begin
    o_ula_op = ULA_ADD;
    case (i_estado)
      EXEC_R: begin
        case (i_opcode)
          OP_SUB:  o_ula_op = ULA_SUB;
          OP_SLT:  o_ula_op = ULA_SLT;
          default: o_ula_op = ULA_ADD;
        endcase
      end
      DESVIO:  o_ula_op = ULA_SUB;
      default: o_ula_op = ULA_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : uc_multiciclo
// Description : Multicycle control unit for the 8-bit nRISC datapath.
//               Sequences fetch/decode/execute/memory/write-back, waits on the
//               memory-ready handshake and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_multiciclo
  import nrisc_pkg::*;
#(
  parameter int CONT_LARGURA = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  uc_multiciclo_if.master  bus
);

  estado_t                 r_estado;
  logic [2:0]              r_opcode;   // opcode captured in DECOD for EXEC_R
  logic [CONT_LARGURA-1:0] r_cont;

  logic                    w_retira;
  logic [1:0]              w_ula_op;
  logic                    w_ula_fonte_a;
  logic [1:0]              w_ula_fonte_b;
  logic [1:0]              w_pc_fonte;
  logic                    w_escreve_pc;
  logic                    w_escreve_ir;
  logic                    w_iord;
  logic                    w_le_mem;
  logic                    w_escreve_mem;
  logic                    w_mem_para_reg;
  logic                    w_escreve_reg;

  // State sequencing; opcode is only looked at in DECOD and CALC_END.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= INICIO;
      r_opcode <= 3'b000;
    end else begin
      case (r_estado)
        INICIO: r_estado <= BUSCA;
        BUSCA:  if (bus.mem_pronta) r_estado <= DECOD;
        DECOD: begin
          r_opcode <= bus.opcode;
          case (bus.opcode)
            OP_ADD, OP_SUB, OP_SLT: r_estado <= EXEC_R;
            OP_ADDI:                r_estado <= EXEC_I;
            OP_LW, OP_SW:           r_estado <= CALC_END;
            OP_BEQ:                 r_estado <= DESVIO;
            default:                r_estado <= SALTO;
          endcase
        end
        EXEC_R:   r_estado <= ESCR_ULA;
        EXEC_I:   r_estado <= ESCR_ULA;
        ESCR_ULA: r_estado <= BUSCA;
        CALC_END: r_estado <= (bus.opcode == OP_SW) ? ESC_MEM : LE_MEM;
        LE_MEM:   if (bus.mem_pronta) r_estado <= ESCR_MEM;
        ESCR_MEM: r_estado <= BUSCA;
        ESC_MEM:  if (bus.mem_pronta) r_estado <= BUSCA;
        DESVIO:   r_estado <= BUSCA;
        SALTO:    r_estado <= BUSCA;
        default:  r_estado <= INICIO;
      endcase
    end
  end

  // An instruction retires on the edge that leaves its last state.
  always_comb begin
    w_retira = 1'b0;
    case (r_estado)
      ESCR_ULA, ESCR_MEM, DESVIO, SALTO: w_retira = 1'b1;
      ESC_MEM:                           w_retira = bus.mem_pronta;
      default:                           w_retira = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cont <= '0;
    end else if (w_retira) begin
      r_cont <= r_cont + 1'b1;
    end
  end

  ula_controle u_ula_controle (
    .i_estado (r_estado),
    .i_opcode (r_opcode),
    .o_ula_op (w_ula_op)
  );

  // Datapath controls decoded from the current state.
  always_comb begin
    w_ula_fonte_a  = 1'b0;
    w_ula_fonte_b  = FONTE_B_REG;
    w_pc_fonte     = PC_ULA;
    w_escreve_pc   = 1'b0;
    w_escreve_ir   = 1'b0;
    w_iord         = 1'b0;
    w_le_mem       = 1'b0;
    w_escreve_mem  = 1'b0;
    w_mem_para_reg = 1'b0;
    w_escreve_reg  = 1'b0;
    case (r_estado)
      BUSCA: begin
        w_le_mem      = 1'b1;
        w_ula_fonte_b = FONTE_B_UM;
        w_escreve_ir  = bus.mem_pronta;
        w_escreve_pc  = bus.mem_pronta;
      end
      DECOD: w_ula_fonte_b = FONTE_B_IMM;
      EXEC_R: w_ula_fonte_a = 1'b1;
      EXEC_I, CALC_END: begin
        w_ula_fonte_a = 1'b1;
        w_ula_fonte_b = FONTE_B_IMM;
      end
      ESCR_ULA: w_escreve_reg = 1'b1;
      LE_MEM: begin
        w_le_mem = 1'b1;
        w_iord   = 1'b1;
      end
      ESCR_MEM: begin
        w_escreve_reg  = 1'b1;
        w_mem_para_reg = 1'b1;
      end
      ESC_MEM: begin
        w_escreve_mem = 1'b1;
        w_iord        = 1'b1;
      end
      DESVIO: begin
        w_ula_fonte_a = 1'b1;
        w_pc_fonte    = PC_ULASAIDA;
        w_escreve_pc  = bus.zero;
      end
      SALTO: begin
        w_pc_fonte   = PC_SALTO;
        w_escreve_pc = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ula_op           = w_ula_op;
  assign bus.ula_fonte_a      = w_ula_fonte_a;
  assign bus.ula_fonte_b      = w_ula_fonte_b;
  assign bus.pc_fonte         = w_pc_fonte;
  assign bus.escreve_pc       = w_escreve_pc;
  assign bus.escreve_ir       = w_escreve_ir;
  assign bus.iord             = w_iord;
  assign bus.le_mem           = w_le_mem;
  assign bus.escreve_mem      = w_escreve_mem;
  assign bus.mem_para_reg     = w_mem_para_reg;
  assign bus.escreve_reg      = w_escreve_reg;
  assign bus.estado           = r_estado;
  assign bus.instr_concluidas = r_cont;

endmodule
`default_nettype wire

// File: tb/tb_uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uc_multiciclo
// Description : Self-checking bench for uc_multiciclo. Expected outputs are
//               queued as each step is driven and popped when sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_multiciclo;
  import nrisc_pkg::*;

  typedef struct packed {
    logic [3:0] estado;
    logic [1:0] ula_op;
    logic       fa;
    logic [1:0] fb;
    logic [1:0] pcf;
    logic       epc;
    logic       eir;
    logic       iord;
    logic       le;
    logic       em;
    logic       m2r;
    logic       er;
    logic [7:0] cnt;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] op_d;
  logic       zero_d;
  logic       mp_d;
  logic [7:0] c;
  int         n_chk;
  int         n_fail;
  obs_t       q[$];

  uc_multiciclo_if #(.CONT_LARGURA(8)) bif ();

  assign bif.opcode     = op_d;
  assign bif.zero       = zero_d;
  assign bif.mem_pronta = mp_d;

  uc_multiciclo #(.CONT_LARGURA(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control outputs for a state, straight from the state table.
  function automatic obs_t spec_out(input estado_t st, input logic [2:0] rop,
                                    input logic z, input logic mp,
                                    input logic [7:0] cnt);
    obs_t o;
    o = '0;
    o.estado = st;
    o.cnt    = cnt;
    case (st)
      BUSCA:    begin o.le = 1; o.fb = 2'b10; o.eir = mp; o.epc = mp; end
      DECOD:    o.fb = 2'b01;
      EXEC_R:   begin
                  o.fa = 1;
                  o.ula_op = (rop == 3'b001) ? 2'b01 : (rop == 3'b010) ? 2'b10 : 2'b00;
                end
      EXEC_I:   begin o.fa = 1; o.fb = 2'b01; end
      ESCR_ULA: o.er = 1;
      CALC_END: begin o.fa = 1; o.fb = 2'b01; end
      LE_MEM:   begin o.le = 1; o.iord = 1; end
      ESCR_MEM: begin o.er = 1; o.m2r = 1; end
      ESC_MEM:  begin o.em = 1; o.iord = 1; end
      DESVIO:   begin o.fa = 1; o.ula_op = 2'b01; o.pcf = 2'b01; o.epc = z; end
      SALTO:    begin o.pcf = 2'b10; o.epc = 1; end
      default:  ;
    endcase
    return o;
  endfunction

  // One clock step: queue the expectation, sample on the falling edge,
  // compare, then advance past the rising edge.
  task automatic step(input estado_t st, input logic [2:0] rop,
                      input bit retira, input string tag);
    obs_t got;
    obs_t exp;
    q.push_back(spec_out(st, rop, zero_d, mp_d, c));
    @(negedge clk);
    got.estado = bif.estado;
    got.ula_op = bif.ula_op;
    got.fa     = bif.ula_fonte_a;
    got.fb     = bif.ula_fonte_b;
    got.pcf    = bif.pc_fonte;
    got.epc    = bif.escreve_pc;
    got.eir    = bif.escreve_ir;
    got.iord   = bif.iord;
    got.le     = bif.le_mem;
    got.em     = bif.escreve_mem;
    got.m2r    = bif.mem_para_reg;
    got.er     = bif.escreve_reg;
    got.cnt    = bif.instr_concluidas;
    exp = q.pop_front();
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
    @(posedge clk);
    #1;
    if (retira) c = c + 8'd1;
  endtask

  task automatic instr_r(input logic [2:0] op, input estado_t ex, input string nm);
    op_d = op;
    step(BUSCA, op, 0, {nm, "/BUSCA"});
    step(DECOD, op, 0, {nm, "/DECOD"});
    step(ex, op, 0, {nm, "/EXEC"});
    step(ESCR_ULA, op, 1, {nm, "/ESCR_ULA"});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    c      = 8'd0;
    rst_n  = 1'b0;
    op_d   = 3'b000;
    zero_d = 1'b0;
    mp_d   = 1'b1;
    @(posedge clk);
    #1;

    // Reset held, then released: INICIO, then BUSCA one cycle later
    step(INICIO, 3'b000, 0, "reset/held0");
    step(INICIO, 3'b000, 0, "reset/held1");
    rst_n = 1'b1;
    step(INICIO, 3'b000, 0, "reset/released");

    // R-type and immediate arithmetic
    instr_r(3'b000, EXEC_R, "ADD");
    instr_r(3'b001, EXEC_R, "SUB");
    // SLT with opcode changed after decode: operation must stay SLT
    op_d = 3'b010;
    step(BUSCA, 3'b010, 0, "SLT/BUSCA");
    step(DECOD, 3'b010, 0, "SLT/DECOD");
    op_d = 3'b111;
    step(EXEC_R, 3'b010, 0, "SLT/EXEC_R");
    step(ESCR_ULA, 3'b010, 1, "SLT/ESCR_ULA");
    instr_r(3'b011, EXEC_I, "ADDI");

    // LW with fetch wait and 3 memory wait cycles
    op_d = 3'b100;
    mp_d = 1'b0;
    step(BUSCA, 3'b100, 0, "LW/BUSCA_wait");
    mp_d = 1'b1;
    step(BUSCA, 3'b100, 0, "LW/BUSCA");
    step(DECOD, 3'b100, 0, "LW/DECOD");
    step(CALC_END, 3'b100, 0, "LW/CALC_END");
    mp_d = 1'b0;
    step(LE_MEM, 3'b100, 0, "LW/LE_MEM_w0");
    step(LE_MEM, 3'b100, 0, "LW/LE_MEM_w1");
    step(LE_MEM, 3'b100, 0, "LW/LE_MEM_w2");
    mp_d = 1'b1;
    step(LE_MEM, 3'b100, 0, "LW/LE_MEM_ok");
    step(ESCR_MEM, 3'b100, 1, "LW/ESCR_MEM");

    // BEQ taken then not taken
    op_d = 3'b110;
    zero_d = 1'b1;
    step(BUSCA, 3'b110, 0, "BEQ1/BUSCA");
    step(DECOD, 3'b110, 0, "BEQ1/DECOD");
    step(DESVIO, 3'b110, 1, "BEQ1/DESVIO_taken");
    zero_d = 1'b0;
    step(BUSCA, 3'b110, 0, "BEQ0/BUSCA");
    step(DECOD, 3'b110, 0, "BEQ0/DECOD");
    step(DESVIO, 3'b110, 1, "BEQ0/DESVIO_not");

    // J, then SW with ready high, then SW with one wait cycle
    op_d = 3'b111;
    step(BUSCA, 3'b111, 0, "J/BUSCA");
    step(DECOD, 3'b111, 0, "J/DECOD");
    step(SALTO, 3'b111, 1, "J/SALTO");
    op_d = 3'b101;
    step(BUSCA, 3'b101, 0, "SW/BUSCA");
    step(DECOD, 3'b101, 0, "SW/DECOD");
    step(CALC_END, 3'b101, 0, "SW/CALC_END");
    step(ESC_MEM, 3'b101, 1, "SW/ESC_MEM");
    step(BUSCA, 3'b101, 0, "SW2/BUSCA");
    step(DECOD, 3'b101, 0, "SW2/DECOD");
    step(CALC_END, 3'b101, 0, "SW2/CALC_END");
    mp_d = 1'b0;
    step(ESC_MEM, 3'b101, 0, "SW2/ESC_MEM_wait");
    mp_d = 1'b1;
    step(ESC_MEM, 3'b101, 1, "SW2/ESC_MEM_ok");

    // Reset asserted in the middle of a pending LW read
    op_d = 3'b100;
    step(BUSCA, 3'b100, 0, "LWr/BUSCA");
    step(DECOD, 3'b100, 0, "LWr/DECOD");
    step(CALC_END, 3'b100, 0, "LWr/CALC_END");
    mp_d = 1'b0;
    step(LE_MEM, 3'b100, 0, "LWr/LE_MEM");
    rst_n = 1'b0;
    c = 8'd0;
    step(INICIO, 3'b100, 0, "LWr/reset_mid");
    rst_n = 1'b1;
    mp_d = 1'b1;
    step(INICIO, 3'b100, 0, "LWr/released");

    // 256 jumps: counter walks through 255 and wraps to 0
    op_d = 3'b111;
    for (int i = 0; i < 256; i++) begin
      step(BUSCA, 3'b111, 0, "wrap/BUSCA");
      step(DECOD, 3'b111, 0, "wrap/DECOD");
      step(SALTO, 3'b111, 1, "wrap/SALTO");
    end
    step(BUSCA, 3'b111, 0, "wrap/after_256");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
